// File: rtl/ekf_stage_scheduler.sv
// ekf_stage_scheduler: issues PRD, then NEW/ASSOC stage commands to the EKF-SLAM core from streamed odometry/observations.
// Optional macro EKF_SCHED_UPD_EN: each ASSOC command is followed by an UPD command on the same feature.
module ekf_stage_scheduler #(
  parameter int DW        = 32,
  parameter int TIME_W    = 16,
  parameter int MAX_FEAT  = 20,
  parameter int FEAT_AW   = 5,
  parameter int ASSOC_WIN = 20,
  parameter int HOLD_CYC  = 2
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [TIME_W-1:0] frame_limit,
  input  logic              odo_val,
  output logic              odo_rdy,
  input  logic [DW-1:0]     odo_vlr,
  input  logic [DW-1:0]     odo_alpha,
  input  logic [TIME_W-1:0] odo_time,
  input  logic              obs_val,
  output logic              obs_rdy,
  input  logic              obs_last,
  input  logic              obs_empty,
  input  logic [DW-1:0]     obs_rk,
  input  logic [DW-1:0]     obs_phi,
  input  logic [TIME_W-1:0] obs_time,
  output logic [2:0]        stage_val,
  output logic [DW-1:0]     vlr,
  output logic [DW-1:0]     alpha,
  output logic [DW-1:0]     rk,
  output logic [DW-1:0]     phi,
  input  logic              stage_rdy,
  output logic              busy,
  output logic              done,
  output logic [TIME_W-1:0] frame_cnt,
  output logic              ovf_err
);

  localparam logic [2:0] STG_IDLE  = 3'd0;
  localparam logic [2:0] STG_PRD   = 3'd1;
  localparam logic [2:0] STG_NEW   = 3'd2;
  localparam logic [2:0] STG_ASSOC = 3'd4;
`ifdef EKF_SCHED_UPD_EN
  localparam logic [2:0] STG_UPD   = 3'd3;
`endif
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic signed [TIME_W:0] WIN = (TIME_W+1)'(ASSOC_WIN);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ODO,
    S_PRD_PULSE,
    S_PRD_WAIT,
    S_CHECK,
    S_FEAT_PULSE,
    S_FEAT_WAIT,
`ifdef EKF_SCHED_UPD_EN
    S_UPD_PULSE,
    S_UPD_WAIT,
`endif
    S_NEXT
  } state_t;

  state_t state, state_next;

  logic [DW-1:0]      feat_rk  [MAX_FEAT];
  logic [DW-1:0]      feat_phi [MAX_FEAT];
  logic [FEAT_AW-1:0] feat_cnt, idx, load_idx;
  logic [HW-1:0]      hold_cnt;
  logic [TIME_W-1:0]  obs_stamp, odo_stamp;
  logic [TIME_W:0]    diff;
  logic [2:0]         stage_next;
  logic obs_full, init_flag;
  logic hold_done, in_window, last_feat;
  logic run_start, run_end, odo_take, prd_ack, frame_drop, frame_done, feat_load;

  assign odo_rdy   = (state == S_GET_ODO);
  assign obs_rdy   = busy & ~obs_full;
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign last_feat = (idx == feat_cnt - FEAT_AW'(1));
  // Observation stamps may precede the odometry stamp; the extra bit keeps the difference signed.
  assign diff      = {1'b0, obs_stamp} - {1'b0, odo_stamp};
  assign in_window = ($signed(diff) <= WIN);

  // State register.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state decode and per-cycle strobes for the datapath.
  always_comb begin
    state_next = state;
    run_start  = 1'b0;
    run_end    = 1'b0;
    odo_take   = 1'b0;
    prd_ack    = 1'b0;
    frame_drop = 1'b0;
    frame_done = 1'b0;
    feat_load  = 1'b0;
    load_idx   = idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          run_start  = 1'b1;
          state_next = S_GET_ODO;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_GET_ODO: begin
        if (odo_val) begin
          odo_take   = 1'b1;
          state_next = S_PRD_PULSE;
        end else begin
          state_next = S_GET_ODO;
        end
      end
      S_PRD_PULSE: begin
        if (hold_done) state_next = S_PRD_WAIT;
        else           state_next = S_PRD_PULSE;
      end
      S_PRD_WAIT: begin
        if (stage_rdy) begin
          prd_ack    = 1'b1;
          state_next = S_CHECK;
        end else begin
          state_next = S_PRD_WAIT;
        end
      end
      S_CHECK: begin
        if (obs_full && in_window) begin
          if (feat_cnt == '0) begin
            frame_drop = 1'b1;
            state_next = S_NEXT;
          end else begin
            feat_load  = 1'b1;
            load_idx   = '0;
            state_next = S_FEAT_PULSE;
          end
        end else begin
          state_next = S_NEXT;
        end
      end
      S_FEAT_PULSE: begin
        if (hold_done) state_next = S_FEAT_WAIT;
        else           state_next = S_FEAT_PULSE;
      end
      S_FEAT_WAIT: begin
        if (!stage_rdy) begin
          state_next = S_FEAT_WAIT;
`ifdef EKF_SCHED_UPD_EN
        end else if (!init_flag) begin
          state_next = S_UPD_PULSE;
`endif
        end else if (last_feat) begin
          frame_done = 1'b1;
          state_next = S_NEXT;
        end else begin
          feat_load  = 1'b1;
          load_idx   = idx + FEAT_AW'(1);
          state_next = S_FEAT_PULSE;
        end
      end
`ifdef EKF_SCHED_UPD_EN
      S_UPD_PULSE: begin
        if (hold_done) state_next = S_UPD_WAIT;
        else           state_next = S_UPD_PULSE;
      end
      S_UPD_WAIT: begin
        if (!stage_rdy) begin
          state_next = S_UPD_WAIT;
        end else if (last_feat) begin
          frame_done = 1'b1;
          state_next = S_NEXT;
        end else begin
          feat_load  = 1'b1;
          load_idx   = idx + FEAT_AW'(1);
          state_next = S_FEAT_PULSE;
        end
      end
`endif
      S_NEXT: begin
        if ((frame_limit != '0) && (frame_cnt == frame_limit)) begin
          run_end    = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_GET_ODO;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Stage code to present on the next cycle; registering it keeps stage_val glitch-free.
  always_comb begin
    case (state_next)
      S_PRD_PULSE:  stage_next = STG_PRD;
      S_FEAT_PULSE: stage_next = init_flag ? STG_NEW : STG_ASSOC;
`ifdef EKF_SCHED_UPD_EN
      S_UPD_PULSE:  stage_next = STG_UPD;
`endif
      default:      stage_next = STG_IDLE;
    endcase
  end

  // Datapath: command outputs, run bookkeeping and the observation loader.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      stage_val <= STG_IDLE;
      hold_cnt  <= '0;
      vlr       <= '0;
      alpha     <= '0;
      rk        <= '0;
      phi       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      ovf_err   <= 1'b0;
      odo_stamp <= '0;
      obs_stamp <= '0;
      idx       <= '0;
      feat_cnt  <= '0;
      obs_full  <= 1'b0;
      init_flag <= 1'b1;
      for (int i = 0; i < MAX_FEAT; i++) begin
        feat_rk[i]  <= '0;
        feat_phi[i] <= '0;
      end
    end else begin
      stage_val <= stage_next;
      hold_cnt  <= (state_next == state) ? hold_cnt + HW'(1) : '0;
      done      <= run_end;
      if (run_start) begin
        busy      <= 1'b1;
        frame_cnt <= '0;
      end else if (run_end) begin
        busy <= 1'b0;
      end else if (prd_ack) begin
        frame_cnt <= frame_cnt + TIME_W'(1);
      end
      if (odo_take) begin
        vlr       <= odo_vlr;
        alpha     <= odo_alpha;
        odo_stamp <= odo_time;
      end
      if (feat_load) begin
        idx <= load_idx;
        rk  <= feat_rk[load_idx];
        phi <= feat_phi[load_idx];
      end
      // The loader only runs while obs_full is clear, so it never races the FSM clearing the frame.
      if (frame_done) begin
        init_flag <= 1'b0;
        obs_full  <= 1'b0;
        feat_cnt  <= '0;
      end else if (frame_drop) begin
        obs_full <= 1'b0;
      end else if (obs_val && obs_rdy) begin
        if (!obs_empty) begin
          if (feat_cnt < FEAT_AW'(MAX_FEAT)) begin
            feat_rk[feat_cnt]  <= obs_rk;
            feat_phi[feat_cnt] <= obs_phi;
            feat_cnt           <= feat_cnt + FEAT_AW'(1);
          end else begin
            ovf_err <= 1'b1;
          end
        end
        if (obs_last) begin
          obs_stamp <= obs_time;
          obs_full  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ekf_stage_scheduler.md
Name: ekf_stage_scheduler

Overview:
- Hardware replacement for the software stage sequencer that drives the EKF-SLAM core.
- Accepts streamed odometry frames (vlr, alpha, time) and observation frames (a variable number of rk/phi features plus a time).
- Issues the PRD, then NEW or ASSOC (optionally UPD) stage commands to the core. Each command is a held stage_val pulse; the block then waits for stage_rdy.
- Sits between the host/DMA input streams and the core's stage_val/vlr/alpha/rk/phi/stage_rdy interface.

Parameters:
- DW, 32, data width (Q1.12.19 signed).
- TIME_W, 16, timestamp width (unsigned).
- MAX_FEAT, 20, feature buffer depth per observation frame.
- FEAT_AW, 5, feature index width; must satisfy 2^FEAT_AW >= MAX_FEAT+1.
- ASSOC_WIN, 20, max (obs_time - odo_time) for an observation to be consumed.
- HOLD_CYC, 2, stage_val pulse length in cycles (>=1).

Ports:
- clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run.
- frame_limit  in  TIME_W  number of PRD rounds per run; 0 = unlimited.
- odo_val  in  1  odometry frame valid.
- odo_rdy  out  1  odometry frame accepted when odo_val&odo_rdy.
- odo_vlr / odo_alpha  in  DW  odometry data.
- odo_time  in  TIME_W  odometry timestamp.
- obs_val  in  1  feature beat valid.
- obs_rdy  out  1  feature beat accepted when obs_val&obs_rdy.
- obs_last  in  1  last beat of frame.
- obs_empty  in  1  frame has zero features (beat data ignored; must come with obs_last).
- obs_rk / obs_phi  in  DW  feature data.
- obs_time  in  TIME_W  frame timestamp, sampled on the obs_last beat.
- stage_val  out  3  core stage command: 0 IDLE, 1 PRD, 2 NEW, 3 UPD, 4 ASSOC.
- vlr / alpha / rk / phi  out  DW  core operands.
- stage_rdy  in  1  core ready.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when frame_limit is reached.
- frame_cnt  out  TIME_W  PRD rounds completed.
- ovf_err  out  1  sticky: a frame had more than MAX_FEAT features.

Behaviour:
- Reset values: all outputs 0. Feature buffer count 0, obs_full 0, init_flag 1, odo_buf_valid 0.
- Reset asserted mid-operation:
  - immediately aborts;
  - stage_val returns to 0 asynchronously;
  - buffered data is discarded.
- Observation loader (runs independently of the main FSM):
  - obs_rdy = busy & ~obs_full.
  - Each accepted beat with obs_empty=0 writes rk/phi at index feat_cnt and increments feat_cnt.
  - Beats arriving when feat_cnt==MAX_FEAT are dropped and set ovf_err.
  - The obs_last beat latches obs_time and sets obs_full.
- Main FSM states: IDLE, GET_ODO, PRD_PULSE, PRD_WAIT, CHECK, FEAT_PULSE, FEAT_WAIT, [UPD_PULSE, UPD_WAIT], NEXT.
- IDLE:
  - start -> busy=1, frame_cnt=0 -> GET_ODO.
  - start while busy is ignored.
- GET_ODO:
  - odo_rdy=1; on handshake, latch vlr/alpha/odo_time -> PRD_PULSE.
  - odo_rdy is 0 in every other state.
- PRD_PULSE: stage_val=1 for exactly HOLD_CYC cycles -> PRD_WAIT.
- PRD_WAIT: stage_val=0; when stage_rdy=1: frame_cnt++ -> CHECK.
- Core contract: stage_rdy falls within HOLD_CYC cycles of stage_val rising.
- CHECK:
  - If ~obs_full -> NEXT.
  - diff = obs_time - odo_time, computed signed in TIME_W+1 bits.
  - If diff <= ASSOC_WIN (negative values included) -> consume the frame.
  - Otherwise -> NEXT, keeping the frame for a later round.
- Consume:
  - Set idx=0.
  - If feat_cnt==0, clear obs_full and go to NEXT.
  - Otherwise go to FEAT_PULSE.
- FEAT_PULSE:
  - rk/phi = buf[idx].
  - stage_val = (init_flag ? 2 : 4) for HOLD_CYC cycles -> FEAT_WAIT.
- FEAT_WAIT: on stage_rdy:
  - if idx==feat_cnt-1: clear init_flag, clear obs_full, set feat_cnt=0 -> NEXT;
  - else idx++ -> FEAT_PULSE.
- NEXT:
  - If frame_limit!=0 && frame_cnt==frame_limit: pulse done, busy=0 -> IDLE.
  - Otherwise -> GET_ODO.
- init_flag is set only by reset. A second run continues in ASSOC mode.
- Operand outputs hold their last values between commands.

Optional Feature:
- Macro: EKF_SCHED_UPD_EN.
- When defined, after each ASSOC command's stage_rdy the FSM issues stage_val=3 (UPD) for HOLD_CYC cycles, with the same rk/phi, and waits for stage_rdy before advancing idx.
- NEW frames never issue UPD.
- When undefined, the UPD states are not compiled and ASSOC advances directly.

Test Plan:
- Reset, start, frame_limit=1, one odometry frame (vlr=0x00100000, alpha=0x00020000, t=100), no observations -> one stage_val=1 pulse, 2 cycles wide, vlr/alpha match, then done pulse, frame_cnt=1, busy=0.
- Odometry t=100 plus a 3-feature observation with t=110 -> PRD, then three stage_val=2 pulses carrying buf[0..2]. A second observation frame with t=130 after an odometry frame with t=120 -> stage_val=4 pulses.
- Observation t=150 against odometry t=100 (diff 50 > 20) -> no feature commands; the frame is retained and consumed after a later odometry frame with t=135.
- 22-beat frame with MAX_FEAT=20 -> 20 commands issued, ovf_err=1 and sticky, obs_rdy remains high through beat 22.
- Assert sys_rst during FEAT_WAIT -> stage_val=0 and busy=0 immediately. The next run's first consumed frame uses NEW (2).
- With EKF_SCHED_UPD_EN defined -> each stage_val=4 pulse is followed by a stage_val=3 pulse carrying identical rk/phi. Without the macro, no stage_val=3 is ever seen.
